// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES
// equal slices with the carry registered between slices, valid/ready on both sides.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int SW = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Whole pipe moves in lock-step; a stalled output freezes every stage, bubbles included.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + ~cin, so borrow-in maps onto an inverted carry-in.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? ~cin : cin;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Operand bits still to be added at this stage: [WIDTH-1 : gi*SW].
            localparam int RW = WIDTH - gi * SW;

            logic                    src_valid;
            logic                    src_c;
            logic [RW-1:0]           src_a;
            logic [RW-1:0]           src_b;
            logic [SW:0]             slice_sum;
            logic [(gi+1)*SW-1:0]    res_next;
            logic                    valid_reg;
            logic                    carry_reg;
            logic [(gi+1)*SW-1:0]    res_reg;

            assign slice_sum = {1'b0, src_a[SW-1:0]} + {1'b0, src_b[SW-1:0]} + (SW+1)'(src_c);

            if (gi == 0) begin : g_src
                assign src_valid = in_valid;
                assign src_c     = c_eff;
                assign src_a     = a;
                assign src_b     = b_eff;
                assign res_next  = slice_sum[SW-1:0];
            end else begin : g_src
                assign src_valid = g_stage[gi-1].valid_reg;
                assign src_c     = g_stage[gi-1].carry_reg;
                assign src_a     = g_stage[gi-1].g_ops.a_reg;
                assign src_b     = g_stage[gi-1].g_ops.b_reg;
                assign res_next  = {slice_sum[SW-1:0], g_stage[gi-1].res_reg};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    res_reg   <= '0;
                end else if (adv) begin
                    valid_reg <= src_valid;
                    carry_reg <= slice_sum[SW];
                    res_reg   <= res_next;
                end
            end

            if (gi < STAGES - 1) begin : g_ops
                // Upper operand slices ride along until their stage consumes them.
                logic [RW-SW-1:0] a_reg;
                logic [RW-SW-1:0] b_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (adv) begin
                        a_reg <= src_a[RW-1:SW];
                        b_reg <= src_b[RW-1:SW];
                    end
                end
            end else begin : g_last
                logic overflow_reg;

                // Signed overflow: like-signed operands producing a result of the other sign.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        overflow_reg <= 1'b0;
                    end else if (adv) begin
                        overflow_reg <= (src_a[RW-1] == src_b[RW-1]) &
                                        (slice_sum[SW-1] != src_a[RW-1]);
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].valid_reg;
    assign sum       = g_stage[STAGES-1].res_reg;
    assign cout      = g_stage[STAGES-1].carry_reg;
    assign overflow  = g_stage[STAGES-1].g_last.overflow_reg;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=32, STAGES=4): directed vectors,
// stall/back-to-back, async reset and a randomized run against a plain arithmetic model.
module tb_pipelined_add_sub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   fail_count = 0;

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: (WIDTH+1)-bit sum of a, effective b and effective carry.
    function automatic exp_t golden(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                    input logic ci, input logic sb);
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   full;
        exp_t             e;
        be   = sb ? ~bb : bb;
        full = {1'b0, aa} + {1'b0, be} + {{WIDTH{1'b0}}, (sb ? ~ci : ci)};
        e.s  = full[WIDTH-1:0];
        e.c  = full[WIDTH];
        e.o  = (aa[WIDTH-1] == be[WIDTH-1]) && (e.s[WIDTH-1] != aa[WIDTH-1]);
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        #3;
        tests_run++;
        if ({out_valid, sum, cout, overflow} !== '0)
            $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b, want all 0",
                     out_valid, sum, cout, overflow);
        tests_run++;
        if (in_ready !== 1'b1) begin
            fail_count++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
        if ({out_valid, sum, cout, overflow} !== '0) fail_count++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            fail_count++;
            $display("FAIL post_reset_valid: got %b, want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'h8000_0000, 32'h10};
        logic [WIDTH-1:0] vb [6] = '{32'h1, 32'h1, 32'h0, 32'h7, 32'h1, 32'h3};
        logic             vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic             vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [WIDTH-1:0] es [6] = '{32'h0, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hC};
        logic             ec [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic             eo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                fail_count++;
                $display("FAIL dir%0d_in_ready: got %b, want 1", i, in_ready);
            end
            @(negedge clk);            // accept edge N has passed
            in_valid = 1'b0;
            repeat (2) @(negedge clk); // after edge N+2
            tests_run++;
            if (out_valid !== 1'b0) begin
                fail_count++;
                $display("FAIL dir%0d_early_valid: got %b at N+2, want 0", i, out_valid);
            end
            @(negedge clk);            // after edge N+3
            tests_run++;
            if (out_valid !== 1'b1 || sum !== es[i] || cout !== ec[i] || overflow !== eo[i]) begin
                fail_count++;
                $display("FAIL dir%0d_result: got v=%b sum=%h c=%b o=%b, want v=1 sum=%h c=%b o=%b",
                         i, out_valid, sum, cout, overflow, es[i], ec[i], eo[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int got = 0;
        int cyc = 0;
        exp_q.delete();
        while ((issued < 8 || exp_q.size() != 0) && cyc < 100) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (issued < 8);
            a = pick_operand(); b = pick_operand();
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            tests_run++;
            if (in_ready !== (!out_valid || out_ready)) begin
                fail_count++;
                $display("FAIL b2b_in_ready cyc%0d: got %b, want %b", cyc, in_ready, !out_valid || out_ready);
            end
            if (out_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fail_count++;
                    $display("FAIL b2b_extra_result cyc%0d: got sum=%h, want no result", cyc, sum);
                end else if ({sum, cout, overflow} !== exp_q[0]) begin
                    fail_count++;
                    $display("FAIL b2b_result cyc%0d: got sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
                             cyc, sum, cout, overflow, exp_q[0].s, exp_q[0].c, exp_q[0].o);
                end
                if (out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(golden(a, b, cin, sub));
                issued++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (got != 8) begin
            fail_count++;
            $display("FAIL b2b_count: got %0d results, want 8", got);
        end
        repeat (5) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                fail_count++;
                $display("FAIL b2b_drain: got out_valid=%b after last op, want 0", out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b1;
        sub = 1'b0; cin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h1234_0000 + i; b = 32'h0000_1111; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b1) begin
            fail_count++;
            $display("FAIL arst_prefill: got out_valid=%b, want 1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
            fail_count++;
            $display("FAIL arst_clear: got v=%b sum=%h c=%b o=%b, want all 0",
                     out_valid, sum, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                fail_count++;
                $display("FAIL arst_stale: got out_valid=%b after release, want 0", out_valid);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int issued = 0;
        int cyc = 0;
        exp_q.delete();
        while ((issued < 3000 || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = (issued < 3000) && ($urandom_range(0, 3) != 0);
            a = pick_operand(); b = pick_operand();
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            if (out_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fail_count++;
                    $display("FAIL rnd_extra_result cyc%0d: got sum=%h, want no result", cyc, sum);
                end else if ({sum, cout, overflow} !== exp_q[0]) begin
                    fail_count++;
                    $display("FAIL rnd_result cyc%0d: got sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
                             cyc, sum, cout, overflow, exp_q[0].s, exp_q[0].c, exp_q[0].o);
                end
                if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(golden(a, b, cin, sub));
                issued++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (issued != 3000 || exp_q.size() != 0) begin
            fail_count++;
            $display("FAIL rnd_complete: got issued=%0d pending=%0d, want 3000 and 0", issued, exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1 rst_n = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
